// File: rtl/tap_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, instruction codes and per-state enable decode.
package tap_pkg;

  localparam int ID_W          = 32;
  localparam int INS_IDCODE    = 1;
  localparam int INS_USER_BASE = 2;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR        = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR        = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_e;

  typedef struct packed {
    logic cap_ir;
    logic shift_ir;
    logic upd_ir;
    logic cap_dr;
    logic shift_dr;
    logic upd_dr;
  } tap_en_t;

  // All-ones code; any code not otherwise decoded also behaves as BYPASS.
  function automatic int ins_bypass(input int ir_w);
    return (1 << ir_w) - 1;
  endfunction

  function automatic tap_en_t decode_en(input tap_state_e s);
    tap_en_t e;
    e.cap_ir   = (s == CAPTURE_IR);
    e.shift_ir = (s == SHIFT_IR);
    e.upd_ir   = (s == UPDATE_IR);
    e.cap_dr   = (s == CAPTURE_DR);
    e.shift_dr = (s == SHIFT_DR);
    e.upd_dr   = (s == UPDATE_DR);
    return e;
  endfunction

endpackage

// File: rtl/tap_ctrl_param_if.sv
// Pad-side serial signals and parallel capture/update bus of the TAP controller.
interface tap_ctrl_param_if #(
  parameter int IR_W   = 4,
  parameter int DR_W   = 8,
  parameter int NUM_DR = 2
);
  logic                   TMS_Pad;
  logic                   TDI_Pad;
  logic                   TDO_Pad;
  logic                   TDO_OE;
  logic [3:0]             tap_state;
  logic [IR_W-1:0]        ir_q;
  logic [NUM_DR*DR_W-1:0] dr_cap_i;
  logic [NUM_DR*DR_W-1:0] dr_upd_q;
  logic [NUM_DR-1:0]      dr_upd_stb;

  modport master (
    output TMS_Pad, TDI_Pad, dr_cap_i,
    input  TDO_Pad, TDO_OE, tap_state, ir_q, dr_upd_q, dr_upd_stb
  );

  modport slave (
    input  TMS_Pad, TDI_Pad, dr_cap_i,
    output TDO_Pad, TDO_OE, tap_state, ir_q, dr_upd_q, dr_upd_stb
  );
endinterface

// File: rtl/tap_fsm.sv
// 16-state TAP controller state machine with registered capture/shift/update enables.
//  state            | meaning
//  TEST_LOGIC_RESET | test logic idle, IR forced to IDCODE
//  RUN_TEST_IDLE    | idle between scans
//  SELECT_DR/IR     | branch point into DR or IR column
//  CAPTURE_DR/IR    | parallel load of selected shift register
//  SHIFT_DR/IR      | serial TDI->TDO shift, one bit per edge
//  EXIT1/EXIT2      | leave shift, towards pause or update
//  PAUSE_DR/IR      | hold shift contents
//  UPDATE_DR/IR     | transfer shift contents to parallel register
module tap_fsm
  import tap_pkg::*;
(
  input  logic       GCLK_Pad,
  input  logic       RSTN_Pad,
  input  logic       TMS_Pad,
  output tap_state_e tap_state,
  output tap_en_t    en,
  output logic       tlr_nxt
);

  tap_state_e state_q, state_d;
  tap_en_t    en_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = TMS_Pad ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = TMS_Pad ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_d = TMS_Pad ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_d = TMS_Pad ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = TMS_Pad ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = TMS_Pad ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = TMS_Pad ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = TMS_Pad ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = TMS_Pad ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_d = TMS_Pad ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = TMS_Pad ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = TMS_Pad ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = TMS_Pad ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = TMS_Pad ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = TMS_Pad ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = TMS_Pad ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // Enables are flopped from the next state so they always match state_q.
  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) begin
      state_q <= TEST_LOGIC_RESET;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= decode_en(state_d);
    end
  end

  assign tap_state = state_q;
  assign en        = en_q;
  assign tlr_nxt   = (state_d == TEST_LOGIC_RESET);

endmodule

// File: rtl/tap_ctrl_param.sv
// Parametrised TAP controller: instruction register, IDCODE, BYPASS and NUM_DR user data registers.
module tap_ctrl_param
  import tap_pkg::*;
#(
  parameter int          IR_W    = 4,
  parameter int          DR_W    = 8,
  parameter int          NUM_DR  = 2,
  parameter logic [31:0] ID_CODE = 32'h1A5E_0001
) (
  input  logic            GCLK_Pad,
  input  logic            RSTN_Pad,
  tap_ctrl_param_if.slave bus
);

  localparam int              UW        = NUM_DR * DR_W;
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(INS_IDCODE);

  tap_state_e state;
  tap_en_t    en;
  logic       tlr_nxt;

  tap_fsm u_fsm (
    .GCLK_Pad  (GCLK_Pad),
    .RSTN_Pad  (RSTN_Pad),
    .TMS_Pad   (bus.TMS_Pad),
    .tap_state (state),
    .en        (en),
    .tlr_nxt   (tlr_nxt)
  );

  logic [IR_W-1:0]   ir_q, ir_d;
  logic [IR_W-1:0]   ir_sh_q, ir_sh_d;
  logic [ID_W-1:0]   id_sh_q, id_sh_d;
  logic [UW-1:0]     usr_sh_q, usr_sh_d;
  logic              byp_q, byp_d;
  logic [UW-1:0]     dr_upd_q, dr_upd_d;
  logic [NUM_DR-1:0] dr_upd_stb_q, dr_upd_stb_d;

  logic              sel_id, sel_byp;
  logic [NUM_DR-1:0] sel_usr;
  logic              tdo_dr;

  always_comb begin
    sel_id  = (ir_q == IR_IDCODE);
    sel_usr = '0;
    for (int k = 0; k < NUM_DR; k++)
      if (ir_q == IR_W'(INS_USER_BASE + k)) sel_usr[k] = 1'b1;
    sel_byp = !sel_id && (sel_usr == '0);
  end

  always_comb begin
    logic [DR_W-1:0] t;
    ir_d         = ir_q;
    ir_sh_d      = ir_sh_q;
    id_sh_d      = id_sh_q;
    usr_sh_d     = usr_sh_q;
    byp_d        = byp_q;
    dr_upd_d     = dr_upd_q;
    dr_upd_stb_d = '0;
    t            = '0;

    if (en.cap_ir) begin
      ir_sh_d    = '0;
      ir_sh_d[0] = 1'b1;
    end
    if (en.shift_ir) ir_sh_d = {bus.TDI_Pad, ir_sh_q[IR_W-1:1]};
    if (en.upd_ir)   ir_d    = ir_sh_q;
    if (tlr_nxt)     ir_d    = IR_IDCODE;

    if (en.cap_dr) begin
      if (sel_id)  id_sh_d = ID_CODE;
      if (sel_byp) byp_d   = 1'b0;
      for (int k = 0; k < NUM_DR; k++)
        if (sel_usr[k]) usr_sh_d[k*DR_W +: DR_W] = bus.dr_cap_i[k*DR_W +: DR_W];
    end

    if (en.shift_dr) begin
      if (sel_id)  id_sh_d = {bus.TDI_Pad, id_sh_q[ID_W-1:1]};
      if (sel_byp) byp_d   = bus.TDI_Pad;
      for (int k = 0; k < NUM_DR; k++) begin
        if (sel_usr[k]) begin
          // Shift form keeps DR_W = 1 legal.
          t         = usr_sh_q[k*DR_W +: DR_W] >> 1;
          t[DR_W-1] = bus.TDI_Pad;
          usr_sh_d[k*DR_W +: DR_W] = t;
        end
      end
    end

    if (en.upd_dr) begin
      for (int k = 0; k < NUM_DR; k++) begin
        if (sel_usr[k]) begin
          dr_upd_d[k*DR_W +: DR_W] = usr_sh_q[k*DR_W +: DR_W];
          dr_upd_stb_d[k]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) begin
      ir_q         <= IR_IDCODE;
      ir_sh_q      <= '0;
      id_sh_q      <= '0;
      usr_sh_q     <= '0;
      byp_q        <= 1'b0;
      dr_upd_q     <= '0;
      dr_upd_stb_q <= '0;
    end else begin
      ir_q         <= ir_d;
      ir_sh_q      <= ir_sh_d;
      id_sh_q      <= id_sh_d;
      usr_sh_q     <= usr_sh_d;
      byp_q        <= byp_d;
      dr_upd_q     <= dr_upd_d;
      dr_upd_stb_q <= dr_upd_stb_d;
    end
  end

  always_comb begin
    tdo_dr = byp_q;
    if (sel_id) tdo_dr = id_sh_q[0];
    for (int k = 0; k < NUM_DR; k++)
      if (sel_usr[k]) tdo_dr = usr_sh_q[k*DR_W];
  end

  assign bus.TDO_Pad    = en.shift_ir ? ir_sh_q[0] : (en.shift_dr ? tdo_dr : 1'b0);
  assign bus.TDO_OE     = en.shift_ir | en.shift_dr;
  assign bus.tap_state  = state;
  assign bus.ir_q       = ir_q;
  assign bus.dr_upd_q   = dr_upd_q;
  assign bus.dr_upd_stb = dr_upd_stb_q;

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Scoreboard bench for tap_ctrl_param: scan tasks push expected TDO bits and update
// records computed from a shift-register queue model; a monitor pops and compares.
module tb_tap_ctrl_param;

  localparam int          IR_W    = 4;
  localparam int          DR_W    = 8;
  localparam int          NUM_DR  = 2;
  localparam int          CW      = NUM_DR * DR_W;
  localparam logic [31:0] ID_CODE = 32'h1A5E_0001;

  localparam logic [3:0] S_TLR = 4'd0, S_RTI = 4'd1, S_SEL_DR = 4'd2, S_CAP_DR = 4'd3,
                         S_EX1_DR = 4'd5, S_PAU_DR = 4'd6, S_EX2_DR = 4'd7, S_UPD_DR = 4'd8,
                         S_PAU_IR = 4'd13;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tap_ctrl_param_if #(.IR_W(IR_W), .DR_W(DR_W), .NUM_DR(NUM_DR)) bus ();

  tap_ctrl_param #(.IR_W(IR_W), .DR_W(DR_W), .NUM_DR(NUM_DR), .ID_CODE(ID_CODE)) dut (
    .GCLK_Pad (clk),
    .RSTN_Pad (rstn),
    .bus      (bus)
  );

  typedef struct {
    logic [NUM_DR-1:0] stb;
    logic [CW-1:0]     vec;
  } upd_t;

  int        n_tests = 0;
  int        n_fail  = 0;
  bit        exp_tdo[$];
  upd_t      exp_upd[$];
  logic [IR_W-1:0] m_ir;
  logic [CW-1:0]   m_upd;
  logic [CW-1:0]   held_upd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which register an instruction selects, its length and captured value.
  function automatic bit is_user(input logic [IR_W-1:0] ir);
    return (int'(ir) >= 2) && (int'(ir) < 2 + NUM_DR);
  endfunction

  function automatic int sel_width(input logic [IR_W-1:0] ir);
    if (ir == 1) return 32;
    if (is_user(ir)) return DR_W;
    return 1;
  endfunction

  function automatic logic [31:0] cap_value(input logic [IR_W-1:0] ir, input logic [CW-1:0] cap);
    logic [31:0] r;
    r = '0;
    if (ir == 1) r = ID_CODE;
    else if (is_user(ir)) r[DR_W-1:0] = cap[(int'(ir)-2)*DR_W +: DR_W];
    return r;
  endfunction

  // Monitor
  initial begin
    held_upd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        held_upd = '0;
        check("rst_stb", bus.dr_upd_stb, 0);
      end else begin
        if (bus.TDO_OE) begin
          if (exp_tdo.size() == 0) check("tdo_unexpected", 1, 0);
          else check("tdo", bus.TDO_Pad, exp_tdo.pop_front());
        end
        if (bus.dr_upd_stb != 0) begin
          if (exp_upd.size() == 0) check("stb_unexpected", bus.dr_upd_stb, 0);
          else begin
            upd_t u;
            u = exp_upd.pop_front();
            check("upd_stb", bus.dr_upd_stb, u.stb);
            held_upd = u.vec;
          end
        end
        check("upd_q", bus.dr_upd_q, held_upd);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic step_c(input bit tms, input bit tdi, input logic [CW-1:0] cap);
    @(negedge clk);
    bus.TMS_Pad  = tms;
    bus.TDI_Pad  = tdi;
    bus.dr_cap_i = cap;
    @(posedge clk);
    #2;
  endtask

  task automatic step(input bit tms, input bit tdi);
    step_c(tms, tdi, CW'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.TMS_Pad = 1'b1;
    #1;
    check("rst_state", bus.tap_state, S_TLR);
    check("rst_ir", bus.ir_q, 1);
    check("rst_upd_q", bus.dr_upd_q, 0);
    check("rst_oe", bus.TDO_OE, 0);
    check("rst_tdo", bus.TDO_Pad, 0);
    repeat (2) @(negedge clk);
    rstn  = 1'b1;
    m_ir  = 1;
    m_upd = '0;
  endtask

  // From RUN_TEST_IDLE, load an instruction and return to RUN_TEST_IDLE.
  task automatic scan_ir(input logic [IR_W-1:0] code);
    for (int i = 0; i < IR_W; i++) exp_tdo.push_back(i == 0);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IR_W; i++) step(i == IR_W - 1, code[i]);
    step(1, 0); step(0, 0);
    m_ir = code;
    check("ir_q", bus.ir_q, code);
  endtask

  // From RUN_TEST_IDLE, scan n bits through the selected DR; optional pause after bit
  // pause_at; abort leaves the FSM in SHIFT_DR for a reset to interrupt.
  task automatic scan_dr(input int n, input logic [63:0] tdi_bits, input int pause_at,
                         input logic [CW-1:0] cap, input bit abort);
    bit              sr[$];
    int              w;
    int              k;
    logic [31:0]     cv;
    logic [DR_W-1:0] v;
    upd_t            u;
    w  = sel_width(m_ir);
    cv = cap_value(m_ir, cap);
    for (int i = 0; i < w; i++) sr.push_back(cv[i]);
    for (int i = 0; i < n; i++) begin
      exp_tdo.push_back(sr.pop_front());
      sr.push_back(tdi_bits[i]);
    end
    if (!abort && is_user(m_ir)) begin
      k = int'(m_ir) - 2;
      for (int j = 0; j < DR_W; j++) v[j] = sr[j];
      m_upd[k*DR_W +: DR_W] = v;
      u.stb = NUM_DR'(1 << k);
      u.vec = m_upd;
      exp_upd.push_back(u);
    end
    step(1, 0); step(0, 0); step_c(0, 0, cap);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && !abort) step(1, tdi_bits[i]);
      else if (i == pause_at) begin
        step(1, tdi_bits[i]); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      end else step(0, tdi_bits[i]);
    end
    if (!abort) begin
      step(1, 0); step(0, 0);
    end
  endtask

  initial begin
    bit          t2_tms[9];
    logic [3:0]  t2_st[9];
    logic [CW-1:0] cap;
    logic [IR_W-1:0] code;
    int          n;
    int          p;
    t2_tms = '{1, 0, 1, 0, 0, 0, 1, 1, 0};
    t2_st  = '{S_SEL_DR, S_CAP_DR, S_EX1_DR, S_PAU_DR, S_PAU_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR, S_RTI};

    bus.TMS_Pad  = 1'b1;
    bus.TDI_Pad  = 1'b0;
    bus.dr_cap_i = '0;
    m_ir  = 1;
    m_upd = '0;
    do_reset();

    repeat (20) step(0, 0);
    check("t1_state", bus.tap_state, S_RTI);
    check("t1_oe", bus.TDO_OE, 0);
    check("t1_ir", bus.ir_q, 1);
    check("t1_upd_q", bus.dr_upd_q, 0);

    for (int i = 0; i < 9; i++) begin
      step(t2_tms[i], 0);
      check("t2_state", bus.tap_state, t2_st[i]);
    end

    scan_dr(32, 64'h0, -1, CW'($urandom), 0);

    scan_ir(4'h3);
    cap = CW'($urandom);
    cap[15:8] = 8'hC3;
    scan_dr(8, 64'h5A, -1, cap, 0);
    check("t4_upd1", bus.dr_upd_q[15:8], 8'h5A);
    check("t4_upd0", bus.dr_upd_q[7:0], 8'h00);

    scan_ir(4'hF);
    scan_dr(4, 64'hD, -1, CW'($urandom), 0);
    scan_ir(4'h9);
    scan_dr(4, 64'hD, -1, CW'($urandom), 0);

    scan_ir(4'h2);
    scan_dr(3, {$urandom, $urandom}, -1, CW'($urandom), 1);
    do_reset();
    step(0, 0);
    check("t6_rst_state", bus.tap_state, S_RTI);

    scan_ir(4'h3);
    exp_tdo.push_back(1'b1);
    exp_tdo.push_back(1'b0);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, $urandom_range(0, 1)); step(1, $urandom_range(0, 1)); step(0, 0);
    check("t6_pause_ir", bus.tap_state, S_PAU_IR);
    repeat (5) step(1, 0);
    check("t6_tms_tlr", bus.tap_state, S_TLR);
    check("t6_tms_ir", bus.ir_q, 1);
    m_ir = 1;
    step(0, 0);

    for (int it = 0; it < 30; it++) begin
      code = IR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) code = IR_W'(2 + $urandom_range(0, NUM_DR - 1));
      scan_ir(code);
      n = $urandom_range(1, 40);
      p = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, n - 2) : -1;
      scan_dr(n, {$urandom, $urandom}, p, CW'($urandom), 0);
    end

    repeat (3) step(0, 0);
    check("tdo_queue_empty", exp_tdo.size(), 0);
    check("upd_queue_empty", exp_upd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
